stream_demux_1_to_2: RTL and testbench

STREAM_DEMUX_1_TO_2 -- requirements
Module: stream_demux_1_to_2

---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_fifo_2.sv | 64 ++++++
 rtl/stream_demux_1_to_2.sv | 75 +++++++
 tb/tb_stream_demux_1_to_2.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package demux_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned FIFO_DEPTH     = 2;
   localparam int unsigned CNT_W          = 16;
   localparam int unsigned LEVEL_W        = $clog2(FIFO_DEPTH + 1);

   typedef logic [LEVEL_W-1:0] level_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   // True when a channel buffer holds FIFO_DEPTH beats.
   function automatic logic is_full(input level_t level);
      return level == level_t'(FIFO_DEPTH);
   endfunction

   // True when a channel buffer holds no beats.
   function automatic logic is_empty(input level_t level);
      return level == level_t'(0);
   endfunction

endpackage

// File: rtl/demux_fifo_2.sv
// Two-entry channel buffer: slot0 is the registered head, slot1 the tail.
module demux_fifo_2
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output level_t           count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;
   level_t           count_q, count_d;
   level_t           wr_level;
   logic             push_ok;
   logic             pop_ok;

   // Next-state: pop shifts the tail into the head, then push fills the first free slot.
   always_comb begin
      slot0_d  = slot0_q;
      slot1_d  = slot1_q;
      count_d  = count_q;
      wr_level = count_q;
      push_ok  = push && !is_full(count_q);
      pop_ok   = pop && !is_empty(count_q);

      if (pop_ok) begin
         slot0_d  = slot1_q;
         count_d  = count_q - level_t'(1);
         wr_level = count_q - level_t'(1);
      end

      if (push_ok) begin
         if (wr_level == level_t'(0)) begin
            slot0_d = din;
         end else begin
            slot1_d = din;
         end
         count_d = count_d + level_t'(1);
      end
   end

   // Storage and fill level; reset empties the buffer and clears the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = slot0_q;

endmodule

// File: rtl/stream_demux_1_to_2.sv
// Routes a valid/ready stream to one of two buffered output channels by sel.
module stream_demux_1_to_2
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   level_t level0;
   level_t level1;
   logic   push0, push1;
   logic   pop0, pop1;
   cnt_t   cnt0_q, cnt1_q;

   // Acceptance depends only on the selected channel's registered fill level.
   assign in_ready = sel ? !is_full(level1) : !is_full(level0);

   // in_valid gates both pushes so sel/in_data are don't-care when idle.
   assign push0 = in_valid && in_ready && !sel;
   assign push1 = in_valid && in_ready && sel;

   assign out0_valid = !is_empty(level0);
   assign out1_valid = !is_empty(level1);
   assign pop0       = out0_valid && out0_ready;
   assign pop1       = out1_valid && out1_ready;

   demux_fifo_2 #(.WIDTH(WIDTH)) u_fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push0),
      .pop   (pop0),
      .din   (in_data),
      .count (level0),
      .head  (out0_data)
   );

   demux_fifo_2 #(.WIDTH(WIDTH)) u_fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push1),
      .pop   (pop1),
      .din   (in_data),
      .count (level1),
      .head  (out1_data)
   );

   // Delivered-beat counters, free-running and wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (pop0) cnt0_q <= cnt0_q + CNT_W'(1);
         if (pop1) cnt1_q <= cnt1_q + CNT_W'(1);
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Bench for stream_demux_1_to_2: directed table, reset/wrap sequences, random traffic.
module tb_stream_demux_1_to_2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        sel;
   logic        out0_valid, out1_valid;
   logic        out0_ready, out1_ready;
   logic [7:0]  out0_data, out1_data;
   logic [15:0] cnt0, cnt1;

   int passed = 0;
   int total  = 0;

   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   logic [15:0] mcnt0 = '0;
   logic [15:0] mcnt1 = '0;
   int          pops0 = 0;
   logic        acc, p0, p1, exp_rdy;
   logic        cur_s;
   logic [7:0]  cur_d;
   logic [7:0]  dummy;

   typedef struct {
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic        r0;
      logic        r1;
      logic        rdy;
      logic        v0;
      logic        v1;
      logic [15:0] c0;
      logic [15:0] c1;
   } vec_t;

   vec_t tab[18];

   stream_demux_1_to_2 #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .sel        (sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive inputs, then compare DUT outputs against the scoreboard before the edge.
   task automatic drive(input logic v, input logic s, input logic [7:0] d,
                        input logic r0, input logic r1);
      in_valid = v; sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
      cur_s = s; cur_d = d;
      #1;
      exp_rdy = s ? (q1.size() < 2) : (q0.size() < 2);
      if (!$isunknown(s)) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
      if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
      chk("cnt0", 32'(cnt0), 32'(mcnt0));
      chk("cnt1", 32'(cnt1), 32'(mcnt1));
      acc = v && exp_rdy;
      p0  = r0 && (q0.size() != 0);
      p1  = r1 && (q1.size() != 0);
   endtask

   // Clock edge: retire popped beats, then record the accepted beat.
   task automatic advance();
      @(posedge clk);
      if (p0) begin dummy = q0.pop_front(); mcnt0 = mcnt0 + 16'd1; pops0++; end
      if (p1) begin dummy = q1.pop_front(); mcnt1 = mcnt1 + 16'd1; end
      if (acc) begin
         if (cur_s) q1.push_back(cur_d);
         else       q0.push_back(cur_d);
      end
      #1;
   endtask

   task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                        input logic r0, input logic r1);
      drive(v, s, d, r0, r1);
      advance();
   endtask

   task automatic do_reset_pulse();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_out0_data", 32'(out0_data), 32'd0);
      chk("rst_out1_data", 32'(out1_data), 32'd0);
      chk("rst_cnt0", 32'(cnt0), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
      sel = 1'b0; #1;
      chk("rst_in_ready_s0", 32'(in_ready), 32'd1);
      sel = 1'b1; #1;
      chk("rst_in_ready_s1", 32'(in_ready), 32'd1);
      q0.delete(); q1.delete();
      mcnt0 = '0; mcnt1 = '0; pops0 = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            v   s   d      r0  r1  rdy v0  v1  c0 c1
      tab[0]  = '{1'b1,1'b0,8'hA5,1'b1,1'b1,1'b1,1'b0,1'b0,16'd0,16'd0};
      tab[1]  = '{1'b1,1'b1,8'h3C,1'b1,1'b1,1'b1,1'b1,1'b0,16'd0,16'd0};
      tab[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b1,16'd1,16'd0};
      tab[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0,16'd1,16'd1};
      tab[4]  = '{1'b1,1'b0,8'h01,1'b0,1'b1,1'b1,1'b0,1'b0,16'd1,16'd1};
      tab[5]  = '{1'b1,1'b0,8'h02,1'b0,1'b1,1'b1,1'b1,1'b0,16'd1,16'd1};
      tab[6]  = '{1'b1,1'b0,8'h03,1'b0,1'b1,1'b0,1'b1,1'b0,16'd1,16'd1};
      tab[7]  = '{1'b1,1'b1,8'h77,1'b0,1'b0,1'b1,1'b1,1'b0,16'd1,16'd1};
      tab[8]  = '{1'b1,1'b0,8'h03,1'b1,1'b1,1'b0,1'b1,1'b1,16'd1,16'd1};
      tab[9]  = '{1'b1,1'b0,8'h03,1'b1,1'b1,1'b1,1'b1,1'b0,16'd2,16'd2};
      tab[10] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1,1'b0,16'd3,16'd2};
      tab[11] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,16'd4,16'd2};
      tab[12] = '{1'b1,1'b1,8'h10,1'b1,1'b0,1'b1,1'b0,1'b0,16'd4,16'd2};
      tab[13] = '{1'b1,1'b1,8'h11,1'b1,1'b1,1'b1,1'b0,1'b1,16'd4,16'd2};
      tab[14] = '{1'b0,1'b1,8'h00,1'b1,1'b0,1'b1,1'b0,1'b1,16'd4,16'd3};
      tab[15] = '{1'b0,1'b1,8'h00,1'b1,1'b0,1'b1,1'b0,1'b1,16'd4,16'd3};
      tab[16] = '{1'b0,1'b1,8'h00,1'b1,1'b1,1'b1,1'b0,1'b1,16'd4,16'd3};
      tab[17] = '{1'b0,1'b1,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,16'd4,16'd4};

      rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      #2;
      chk("init_out0_valid", 32'(out0_valid), 32'd0);
      chk("init_out1_valid", 32'(out1_valid), 32'd0);
      chk("init_cnt0", 32'(cnt0), 32'd0);
      chk("init_cnt1", 32'(cnt1), 32'd0);
      chk("init_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed table: routing, backpressure, no head-of-line block, push+pop.
      for (int i = 0; i < 18; i++) begin
         drive(tab[i].v, tab[i].s, tab[i].d, tab[i].r0, tab[i].r1);
         chk($sformatf("tab%0d_in_ready", i), 32'(in_ready), 32'(tab[i].rdy));
         chk($sformatf("tab%0d_out0_valid", i), 32'(out0_valid), 32'(tab[i].v0));
         chk($sformatf("tab%0d_out1_valid", i), 32'(out1_valid), 32'(tab[i].v1));
         chk($sformatf("tab%0d_cnt0", i), 32'(cnt0), 32'(tab[i].c0));
         chk($sformatf("tab%0d_cnt1", i), 32'(cnt1), 32'(tab[i].c1));
         if (i == 1)  chk("route_out0_data", 32'(out0_data), 32'h A5);
         if (i == 2)  chk("route_out1_data", 32'(out1_data), 32'h 3C);
         if (i == 8)  chk("hol_out1_data", 32'(out1_data), 32'h 77);
         if (i == 13) chk("pp_head_before", 32'(out1_data), 32'h 10);
         if (i == 14) chk("pp_head_after", 32'(out1_data), 32'h 11);
         if (i == 15) chk("hold_out1_data", 32'(out1_data), 32'h 11);
         advance();
      end

      // Idle cycle with unknown sel/data must not disturb any state.
      cycle(1'b0, 1'bx, 8'hxx, 1'b0, 1'b0);

      // Mid-operation reset with both channels holding beats.
      cycle(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("pre_rst_out0_valid", 32'(out0_valid), 32'd1);
      chk("pre_rst_out1_valid", 32'(out1_valid), 32'd1);
      do_reset_pulse();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // Counter wrap: 65536 pops on channel 0 starting from zero.
      while (pops0 < 65536) begin
         cycle(1'b1, 1'b0, 8'(pops0), 1'b1, 1'b0);
         if (pops0 == 65535) chk("wrap_cnt0_ffff", 32'(cnt0), 32'h FFFF);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("wrap_cnt0_zero", 32'(cnt0), 32'h 0000);
      advance();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("drain_out0_valid", 32'(out0_valid), 32'd0);
      chk("drain_out1_valid", 32'(out1_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
